// File: rtl/multiphase_sine_generator.sv
// multiphase_sine_generator: NUM_CH phase-shifted sine references from one phase
// accumulator, a quarter-wave LUT and one time-shared multiplier.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     run enable (low clears phase, MI ramp and outputs)
//   sample_tick                starts one sample computation
//   freq_increment             requested phase increment per accepted tick
//   modulation_index           requested MI (saturated to full scale)
//   update_req                 captures freq/MI into shadow registers
//   update_pending             a captured update waits for the next wrap
//   period_start               pulse after an accumulator wrap
//   busy                       sequencer is computing
//   sample_valid               pulse when sine_out updates
//   tick_overrun               pulse when a tick arrives while busy
//   sine_out                   channel k at [k*DATA_WIDTH +: DATA_WIDTH], signed
module multiphase_sine_generator #(
    parameter int DATA_WIDTH = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int NUM_CH = 3,
    parameter logic [PHASE_WIDTH-1:0] PHASE_STEP = 32'h5555_5555,
    parameter int RAMP_STEP = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           sample_tick,
    input  logic [PHASE_WIDTH-1:0]         freq_increment,
    input  logic [DATA_WIDTH-1:0]          modulation_index,
    input  logic                           update_req,
    output logic                           update_pending,
    output logic                           period_start,
    output logic                           busy,
    output logic                           sample_valid,
    output logic                           tick_overrun,
    output logic [NUM_CH*DATA_WIDTH-1:0]   sine_out
);
    localparam int QW = LUT_ADDR_WIDTH - 2;
    localparam int Q = 1 << QW;
    localparam int CW = $clog2(NUM_CH + 2);
    localparam int FS = (1 << (DATA_WIDTH - 1)) - 1;
    localparam logic [DATA_WIDTH-1:0] MI_MAX = DATA_WIDTH'(FS);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    // Elaboration-time sine via Taylor series; the last entry is pinned to full
    // scale so rounding in the series cannot truncate it to FS-1.
    function automatic logic [DATA_WIDTH-1:0] lut_val(input int j);
        real x, term, s;
        x = 3.14159265358979323846 * j / (2.0 * Q);
        term = x;
        s = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / ((2 * n) * (2 * n + 1));
            s = s + term;
        end
        return (j == Q) ? MI_MAX : DATA_WIDTH'($rtoi(FS * s));
    endfunction

    logic [DATA_WIDTH-1:0] lut [Q+1];
    for (genvar j = 0; j <= Q; j++) begin : g_lut
        assign lut[j] = lut_val(j);
    end

    state_t state, state_nxt;
    logic [PHASE_WIDTH-1:0] phase_acc, freq_active, freq_shadow, ch_phase, phase_sum;
    logic [DATA_WIDTH-1:0] mi_active, mi_target, mi_shadow, mi_next, mi_diff, mi_step, l_val;
    logic pending, accept, wrap, carry, mi_up, a_v, l_v, l_neg;
    logic [CW-1:0] cnt, a_ch, l_ch;
    logic [LUT_ADDR_WIDTH-1:0] a_q;
    logic [QW:0] idx;
    logic signed [DATA_WIDTH-1:0] l_s;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic [NUM_CH*DATA_WIDTH-1:0] stage;

    assign busy = state != IDLE;
    assign update_pending = pending;

    // A stopped accumulator (freq_active == 0) never carries, so a pending update
    // is taken on the next accepted tick instead; otherwise it could never apply.
    always_comb begin
        accept = enable && state == IDLE && sample_tick;
        state_nxt = !enable ? IDLE :
                    accept ? CALC :
                    (state == CALC && cnt == CW'(NUM_CH + 1)) ? OUT :
                    (state == OUT) ? IDLE : state;
        {carry, phase_sum} = {1'b0, phase_acc} + {1'b0, freq_active};
        wrap = carry || (freq_active == '0 && pending);
        mi_up = mi_target > mi_active;
        mi_diff = mi_up ? mi_target - mi_active : mi_active - mi_target;
        mi_step = (mi_diff > DATA_WIDTH'(RAMP_STEP)) ? DATA_WIDTH'(RAMP_STEP) : mi_diff;
        mi_next = mi_up ? mi_active + mi_step : mi_active - mi_step;
        idx = a_q[LUT_ADDR_WIDTH-2] ? (QW+1)'(Q) - {1'b0, a_q[QW-1:0]} : {1'b0, a_q[QW-1:0]};
        l_s = l_neg ? -$signed(l_val) : $signed(l_val);
        prod = l_s * $signed(mi_active);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    // ch_phase holds the snapped phase and then steps by PHASE_STEP per issued
    // channel; the pipeline is address -> LUT read -> multiply into staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc <= '0;
            freq_active <= '0;
            freq_shadow <= '0;
            ch_phase <= '0;
            mi_active <= '0;
            mi_target <= '0;
            mi_shadow <= '0;
            pending <= 1'b0;
            period_start <= 1'b0;
            tick_overrun <= 1'b0;
            sample_valid <= 1'b0;
            sine_out <= '0;
            stage <= '0;
            cnt <= '0;
            a_v <= 1'b0;
            a_q <= '0;
            a_ch <= '0;
            l_v <= 1'b0;
            l_val <= '0;
            l_neg <= 1'b0;
            l_ch <= '0;
        end else begin
            if (update_req) begin
                freq_shadow <= freq_increment;
                mi_shadow <= modulation_index[DATA_WIDTH-1] ? MI_MAX : modulation_index;
                pending <= 1'b1;
            end else if (accept && wrap) begin
                pending <= 1'b0;
            end
            period_start <= accept && wrap;
            tick_overrun <= enable && sample_tick && state != IDLE;
            sample_valid <= enable && state == OUT;
            if (!enable) begin
                phase_acc <= '0;
                mi_active <= '0;
                sine_out <= '0;
            end else begin
                if (accept) begin
                    ch_phase <= phase_acc;
                    phase_acc <= phase_sum;
                    mi_active <= mi_next;
                    cnt <= '0;
                    a_v <= 1'b0;
                    l_v <= 1'b0;
                    if (wrap && pending) begin
                        freq_active <= freq_shadow;
                        mi_target <= mi_shadow;
                    end
                end
                if (state == CALC) begin
                    ch_phase <= ch_phase + PHASE_STEP;
                    cnt <= cnt + 1'b1;
                    a_v <= cnt < CW'(NUM_CH);
                    a_q <= ch_phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
                    a_ch <= cnt;
                    l_v <= a_v;
                    l_val <= lut[idx];
                    l_neg <= a_q[LUT_ADDR_WIDTH-1];
                    l_ch <= a_ch;
                    if (l_v) stage[int'(l_ch) * DATA_WIDTH +: DATA_WIDTH] <= prod[DATA_WIDTH-1 +: DATA_WIDTH];
                end
                if (state == OUT) sine_out <= stage;
            end
        end
    end
endmodule

// File: tb/tb_multiphase_sine_generator.sv
// tb_multiphase_sine_generator: directed scoreboard bench for multiphase_sine_generator.
module tb_multiphase_sine_generator;
    localparam int NCH = 3;

    logic clk = 0, rst_n = 0, enable = 0, sample_tick = 0, update_req = 0;
    logic [31:0] freq_increment = '0;
    logic [15:0] modulation_index = '0;
    logic update_pending, period_start, busy, sample_valid, tick_overrun;
    logic [NCH*16-1:0] sine_out;

    int n_assert = 0, n_fail = 0;
    logic [NCH*16-1:0] sb[$];

    logic [31:0] m_phase = '0, m_freq = '0, m_fsh = '0;
    logic [15:0] m_mi = '0, m_mit = '0, m_msh = '0;
    logic m_pend = 0;

    multiphase_sine_generator dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
        .freq_increment(freq_increment), .modulation_index(modulation_index),
        .update_req(update_req), .update_pending(update_pending),
        .period_start(period_start), .busy(busy), .sample_valid(sample_valid),
        .tick_overrun(tick_overrun), .sine_out(sine_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint lut_ref(input int j);
        return longint'($rtoi(32767.0 * $sin(3.141592653589793 / 2.0 * j / 64.0)));
    endfunction

    function automatic logic [15:0] chan_ref(input logic [7:0] a, input logic [15:0] mi);
        longint v, p;
        int i;
        i = int'(a[5:0]);
        v = lut_ref(a[6] ? 64 - i : i);
        if (a[7]) v = -v;
        p = v * longint'(mi);
        p = p >>> 15;
        return p[15:0];
    endfunction

    function automatic logic [15:0] ramp(input logic [15:0] a, input logic [15:0] t);
        if (t > a) return (t - a > 16) ? a + 16 : t;
        return (a - t > 16) ? a - 16 : t;
    endfunction

    task automatic upd(input logic [31:0] f, input logic [15:0] m);
        @(negedge clk);
        update_req = 1;
        freq_increment = f;
        modulation_index = m;
        m_fsh = f;
        m_msh = m[15] ? 16'h7FFF : m;
        m_pend = 1;
        @(negedge clk);
        update_req = 0;
        check("pending_set", update_pending, 1);
    endtask

    // mode 0: normal, 1: extra tick while busy, 2: enable dropped mid-CALC
    task automatic run_tick(input int mode, input bit u, input logic [31:0] f, input logic [15:0] m);
        logic [32:0] s;
        logic w, seen;
        logic [31:0] sn, p;
        logic [NCH*16-1:0] e;
        int k;
        @(negedge clk);
        sample_tick = 1;
        update_req = u;
        freq_increment = f;
        modulation_index = m;
        s = {1'b0, m_phase} + {1'b0, m_freq};
        w = s[32] | (m_freq == 0 && m_pend);
        sn = m_phase;
        m_phase = s[31:0];
        m_mi = ramp(m_mi, m_mit);
        if (w && m_pend) begin
            m_freq = m_fsh;
            m_mit = m_msh;
            m_pend = 0;
        end
        if (u) begin
            m_fsh = f;
            m_msh = m[15] ? 16'h7FFF : m;
            m_pend = 1;
        end
        for (int c = 0; c < NCH; c++) begin
            p = sn + 32'h5555_5555 * c;
            e[c*16 +: 16] = chan_ref(p[31:24], m_mi);
        end
        if (mode != 2) sb.push_back(e);
        @(negedge clk);
        sample_tick = 0;
        update_req = 0;
        check("period_start", period_start, w);
        check("update_pending", update_pending, m_pend);
        check("busy", busy, 1);
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = sample_valid;
            if (mode == 1) sample_tick = (k == 2);
            if (mode == 2 && k == 2) enable = 0;
            if (k == 3) check("tick_overrun", tick_overrun, mode == 1);
            if (mode == 2 && k == 3) begin
                check("abort_sine", sine_out, 0);
                check("abort_busy", busy, 0);
            end
        end
        if (mode == 2) begin
            check("abort_no_valid", seen, 0);
            enable = 1;
            m_phase = '0;
            m_mi = '0;
        end else begin
            check("valid_seen", seen, 1);
            check("latency", k, NCH + 3);
            e = sb.pop_front();
            for (int c = 0; c < NCH; c++)
                check($sformatf("sine_ch%0d", c), $signed(sine_out[c*16 +: 16]), $signed(e[c*16 +: 16]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sine", sine_out, 0);
        check("rst_pending", update_pending, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_period", period_start, 0);
        check("rst_overrun", tick_overrun, 0);
        rst_n = 1;
        enable = 1;
        upd(32'h0100_0000, 16'd32767);
        run_tick(0, 0, '0, '0);
        repeat (2048) run_tick(0, 0, '0, '0);
        run_tick(0, 0, '0, '0);
        run_tick(1, 0, '0, '0);
        run_tick(0, 0, '0, '0);
        upd(32'h0100_0000, 16'd20000);
        repeat (10) run_tick(0, 0, '0, '0);
        upd(32'h0100_0000, 16'd16384);
        repeat (260) run_tick(0, 0, '0, '0);
        repeat (1100) run_tick(0, 0, '0, '0);
        repeat (256) run_tick(0, 0, '0, '0);
        upd(32'h0100_0000, 16'd12000);
        while ({1'b0, m_phase} + {1'b0, m_freq} < 33'h1_0000_0000) run_tick(0, 0, '0, '0);
        run_tick(0, 1, 32'h0200_0000, 16'hFFFF);
        repeat (140) run_tick(0, 0, '0, '0);
        run_tick(2, 0, '0, '0);
        repeat (5) run_tick(0, 0, '0, '0);
        @(negedge clk);
        sample_tick = 1;
        @(negedge clk);
        sample_tick = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_sine", sine_out, 0);
        check("async_busy", busy, 0);
        check("async_pending", update_pending, 0);
        check("async_valid", sample_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_sine", sine_out, 0);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
